// File: rtl/snake_body.sv
// Snake body: segment shift register with a RUN/MOVE/CHECK/DEAD move sequencer; qhit has 1-cycle latency.
// Backpressure: ticks arriving while a move is in flight (MOVE/CHECK) are dropped, never queued.
module snake_body #(
  parameter int MAXLEN = 16,
  parameter int XMAX   = 38,
  parameter int YMAX   = 28
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic [1:0] dir,
  input  logic       add,
  input  logic [5:0] qx,
  input  logic [5:0] qy,
  output logic [5:0] headx,
  output logic [5:0] heady,
  output logic [5:0] length,
  output logic       qhit,
  output logic       dead
);

  localparam int IW = $clog2(MAXLEN);
  localparam logic [5:0] XM     = 6'(XMAX);
  localparam logic [5:0] YM     = 6'(YMAX);
  localparam logic [5:0] LENMAX = 6'(MAXLEN);

  typedef enum logic [1:0] {RUN, MOVE, CHECK, DEAD} state_t;

  state_t        state;
  logic [5:0]    sx [MAXLEN];
  logic [5:0]    sy [MAXLEN];
  logic [1:0]    heading;
  logic [5:0]    nx, ny;
  logic [IW-1:0] k;
  logic          grow_pending;
  logic          add_d;

  logic [1:0]    eff_dir;
  logic [5:0]    cx, cy;
  logic          wall;
  logic          add_rise;
  logic          hit_k;
  logic          q_any;

  assign headx    = sx[0];
  assign heady    = sy[0];
  assign add_rise = add & ~add_d;
  assign hit_k    = (sx[k] == sx[0]) && (sy[k] == sy[0]);

  // Reverse of a heading differs only in bit 0 (up/down, left/right).
  assign eff_dir = (dir == {heading[1], ~heading[0]}) ? heading : dir;

  always_comb begin
    cx = sx[0];
    cy = sy[0];
    case (eff_dir)
      2'd0: cy = sy[0] - 6'd1;
      2'd1: cy = sy[0] + 6'd1;
      2'd2: cx = sx[0] - 6'd1;
      2'd3: cx = sx[0] + 6'd1;
    endcase
  end

  // Legal coordinates are >= 1, so a 6-bit decrement lands on 0 rather than wrapping.
  assign wall = (cx == 6'd0) || (cx > XM) || (cy == 6'd0) || (cy > YM);

  always_comb begin
    q_any = 1'b0;
    for (int i = 0; i < MAXLEN; i++) begin
      if ((6'(i) < length) && (sx[i] == qx) && (sy[i] == qy))
        q_any = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RUN;
      heading      <= 2'd3;
      length       <= 6'd3;
      grow_pending <= 1'b0;
      add_d        <= 1'b0;
      dead         <= 1'b0;
      qhit         <= 1'b0;
      nx           <= 6'd0;
      ny           <= 6'd0;
      k            <= IW'(1);
      for (int i = 0; i < MAXLEN; i++) begin
        sx[i] <= 6'd0;
        sy[i] <= 6'd0;
      end
      sx[0] <= 6'd20; sy[0] <= 6'd15;
      sx[1] <= 6'd19; sy[1] <= 6'd15;
      sx[2] <= 6'd18; sy[2] <= 6'd15;
    end else begin
      add_d <= add;
      qhit  <= q_any;
      case (state)
        RUN: begin
          if (add_rise)
            grow_pending <= 1'b1;
          if (tick) begin
            heading <= eff_dir;
            if (wall) begin
              state <= DEAD;
              dead  <= 1'b1;
            end else begin
              nx    <= cx;
              ny    <= cy;
              state <= MOVE;
            end
          end
        end
        MOVE: begin
          for (int i = 1; i < MAXLEN; i++) begin
            sx[i] <= sx[i-1];
            sy[i] <= sy[i-1];
          end
          sx[0] <= nx;
          sy[0] <= ny;
          // A fresh add edge in the consuming cycle survives as the next pending grow.
          if (grow_pending) begin
            if (length < LENMAX)
              length <= length + 6'd1;
            grow_pending <= add_rise;
          end else if (add_rise) begin
            grow_pending <= 1'b1;
          end
          k     <= IW'(1);
          state <= CHECK;
        end
        CHECK: begin
          if (add_rise)
            grow_pending <= 1'b1;
          if (hit_k) begin
            state <= DEAD;
            dead  <= 1'b1;
          end else if (6'(k) == length - 6'd1) begin
            state <= RUN;
          end else begin
            k <= k + IW'(1);
          end
        end
        DEAD: ;
      endcase
    end
  end

endmodule

// File: tb/tb_snake_body.sv
// Randomized and directed bench for snake_body against a queue-based behavioural model.
module tb_snake_body;
  localparam int MAXLEN = 16;
  localparam int XMAX   = 38;
  localparam int YMAX   = 28;

  logic       clk = 1'b0;
  logic       rst, tick, add;
  logic [1:0] dir;
  logic [5:0] qx, qy;
  logic [5:0] headx, heady, length;
  logic       qhit, dead;

  snake_body #(.MAXLEN(MAXLEN), .XMAX(XMAX), .YMAX(YMAX)) dut (
    .clk(clk), .rst(rst), .tick(tick), .dir(dir), .add(add), .qx(qx), .qy(qy),
    .headx(headx), .heady(heady), .length(length), .qhit(qhit), .dead(dead)
  );

  always #20 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  typedef struct {int x; int y;} pt_t;
  pt_t body[$];
  int  m_dir, m_busy;
  bit  m_gp, m_addp, m_dead, m_mp, m_coll, m_qhit;
  pt_t m_nh;

  function automatic int opp(input int d);
    case (d)
      0: return 1;
      1: return 0;
      2: return 3;
      default: return 2;
    endcase
  endfunction

  function automatic bit member(input int x, input int y);
    foreach (body[i])
      if (body[i].x == x && body[i].y == y) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    body.delete();
    body.push_back('{20, 15});
    body.push_back('{19, 15});
    body.push_back('{18, 15});
    m_dir = 3; m_busy = 0;
    m_gp = 0; m_addp = 0; m_dead = 0; m_mp = 0; m_coll = 0; m_qhit = 0;
  endtask

  task automatic model_edge(input bit t, input int d, input bit a, input bit r, input int x, input int y);
    bit rise;
    int hd, nxx, nyy;
    if (r) begin
      model_reset();
      return;
    end
    rise   = a && !m_addp;
    m_addp = a;
    m_qhit = member(x, y);
    if (m_dead) begin
    end else if (m_mp) begin
      m_mp = 0;
      body.push_front(m_nh);
      if (!(m_gp && body.size() <= MAXLEN)) void'(body.pop_back());
      m_gp   = rise;
      m_coll = 0;
      m_busy = body.size() - 1;
      for (int j = 1; j < body.size(); j++) begin
        if (body[j].x == body[0].x && body[j].y == body[0].y) begin
          m_coll = 1;
          m_busy = j;
          break;
        end
      end
    end else if (m_busy > 0) begin
      m_gp = m_gp | rise;
      m_busy--;
      if (m_busy == 0 && m_coll) m_dead = 1;
    end else begin
      m_gp = m_gp | rise;
      if (t) begin
        hd    = (d == opp(m_dir)) ? m_dir : d;
        m_dir = hd;
        nxx   = body[0].x + ((hd == 3) ? 1 : (hd == 2) ? -1 : 0);
        nyy   = body[0].y + ((hd == 1) ? 1 : (hd == 0) ? -1 : 0);
        if (nxx < 1 || nxx > XMAX || nyy < 1 || nyy > YMAX) m_dead = 1;
        else begin
          m_nh = '{nxx, nyy};
          m_mp = 1;
        end
      end
    end
  endtask

  task automatic step(input bit t, input logic [1:0] d, input bit a, input bit r,
                      input logic [5:0] x, input logic [5:0] y);
    tick = t; dir = d; add = a; rst = r; qx = x; qy = y;
    @(posedge clk);
    model_edge(t, int'(d), a, r, int'(x), int'(y));
    #1;
    chk("headx",  32'(headx),  32'(body[0].x));
    chk("heady",  32'(heady),  32'(body[0].y));
    chk("length", 32'(length), 32'(body.size()));
    chk("dead",   32'(dead),   32'(m_dead));
    chk("qhit",   32'(qhit),   32'(m_qhit));
  endtask

  task automatic idle(input int n, input bit a);
    repeat (n) step(1'b0, 2'd0, a, 1'b0, 6'd0, 6'd0);
  endtask

  task automatic do_reset();
    step(1'b0, 2'd0, 1'b0, 1'b1, 6'd0, 6'd0);
  endtask

  initial begin
    logic [1:0] rd;
    logic [5:0] rx, ry;
    bit         ra;
    int         pick;
    tick = 0; dir = 0; add = 0; rst = 1; qx = 0; qy = 0;
    model_reset();
    do_reset();
    do_reset();
    chk("reset_len",  32'(length), 32'd3);
    chk("reset_head", 32'({headx, heady}), 32'({6'd20, 6'd15}));
    chk("reset_dead", 32'(dead), 32'd0);
    chk("reset_qhit", 32'(qhit), 32'd0);

    step(1'b0, 2'd0, 1'b0, 1'b0, 6'd19, 6'd15);
    chk("query_hit", 32'(qhit), 32'd1);
    step(1'b0, 2'd0, 1'b0, 1'b0, 6'd22, 6'd15);
    chk("query_miss", 32'(qhit), 32'd0);

    step(1'b1, 2'd3, 1'b0, 1'b0, 6'd0, 6'd0);
    idle(4, 1'b0);
    chk("move_head", 32'({headx, heady}), 32'({6'd21, 6'd15}));
    chk("move_len",  32'(length), 32'd3);
    step(1'b0, 2'd0, 1'b0, 1'b0, 6'd19, 6'd15);
    chk("move_seg2", 32'(qhit), 32'd1);
    step(1'b0, 2'd0, 1'b0, 1'b0, 6'd18, 6'd15);
    chk("move_old_tail", 32'(qhit), 32'd0);

    // Reversal is ignored and leaves the heading at right.
    do_reset();
    step(1'b1, 2'd2, 1'b0, 1'b0, 6'd0, 6'd0);
    idle(4, 1'b0);
    chk("rev_head1", 32'({headx, heady}), 32'({6'd21, 6'd15}));
    step(1'b1, 2'd2, 1'b0, 1'b0, 6'd0, 6'd0);
    idle(4, 1'b0);
    chk("rev_head2", 32'({headx, heady}), 32'({6'd22, 6'd15}));

    do_reset();
    idle(100, 1'b1);
    idle(1, 1'b0);
    step(1'b1, 2'd3, 1'b0, 1'b0, 6'd0, 6'd0);
    idle(5, 1'b0);
    chk("grow_len1", 32'(length), 32'd4);
    step(1'b1, 2'd3, 1'b0, 1'b0, 6'd0, 6'd0);
    idle(6, 1'b0);
    chk("grow_len2", 32'(length), 32'd4);

    do_reset();
    repeat (18) begin
      step(1'b1, 2'd3, 1'b0, 1'b0, 6'd0, 6'd0);
      idle(4, 1'b0);
    end
    chk("wall_edge_head", 32'({headx, heady}), 32'({6'd38, 6'd15}));
    chk("wall_edge_dead", 32'(dead), 32'd0);
    step(1'b1, 2'd3, 1'b0, 1'b0, 6'd0, 6'd0);
    chk("wall_dead", 32'(dead), 32'd1);
    chk("wall_head", 32'({headx, heady}), 32'({6'd38, 6'd15}));
    step(1'b1, 2'd1, 1'b1, 1'b0, 6'd0, 6'd0);
    idle(5, 1'b0);
    step(1'b1, 2'd0, 1'b0, 1'b0, 6'd0, 6'd0);
    idle(5, 1'b0);
    chk("dead_frozen_head", 32'({headx, heady}), 32'({6'd38, 6'd15}));
    chk("dead_frozen_len",  32'(length), 32'd3);

    do_reset();
    step(1'b0, 2'd0, 1'b1, 1'b0, 6'd0, 6'd0);
    step(1'b1, 2'd3, 1'b0, 1'b0, 6'd0, 6'd0);
    idle(5, 1'b0);
    step(1'b0, 2'd0, 1'b1, 1'b0, 6'd0, 6'd0);
    step(1'b1, 2'd3, 1'b0, 1'b0, 6'd0, 6'd0);
    idle(6, 1'b0);
    chk("self_len", 32'(length), 32'd5);
    step(1'b1, 2'd1, 1'b0, 1'b0, 6'd0, 6'd0);
    idle(7, 1'b0);
    step(1'b1, 2'd2, 1'b0, 1'b0, 6'd0, 6'd0);
    idle(7, 1'b0);
    chk("self_alive", 32'(dead), 32'd0);
    step(1'b1, 2'd0, 1'b0, 1'b0, 6'd0, 6'd0);
    idle(7, 1'b0);
    chk("self_dead", 32'(dead), 32'd1);
    chk("self_head", 32'({headx, heady}), 32'({6'd21, 6'd15}));

    // Reset while the collision scan is in progress.
    do_reset();
    step(1'b1, 2'd3, 1'b0, 1'b0, 6'd0, 6'd0);
    idle(1, 1'b0);
    step(1'b0, 2'd0, 1'b0, 1'b1, 6'd21, 6'd15);
    chk("midchk_len",  32'(length), 32'd3);
    chk("midchk_head", 32'({headx, heady}), 32'({6'd20, 6'd15}));
    chk("midchk_dead", 32'(dead), 32'd0);
    chk("midchk_qhit", 32'(qhit), 32'd0);

    ra = 1'b0;
    for (int c = 0; c < 5000; c++) begin
      if ($urandom_range(0, 7) == 0) ra = ~ra;
      rd   = 2'($urandom_range(0, 3));
      pick = $urandom_range(0, body.size() - 1);
      if ($urandom_range(0, 1) == 0) begin
        rx = 6'(body[pick].x);
        ry = 6'(body[pick].y);
      end else begin
        rx = 6'($urandom_range(0, 63));
        ry = 6'($urandom_range(0, 63));
      end
      step($urandom_range(0, 2) == 0, rd, ra,
           ($urandom_range(0, 599) == 0) || (m_dead && $urandom_range(0, 19) == 0), rx, ry);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/snake_body.md
SNAKE_BODY -- requirements
Module: snake_body

Interface
REQ-001 Parameter: MAXLEN, default 16, maximum segment count (power of two, 4..32).
REQ-002 Parameter: XMAX, default 38, rightmost legal column; legal x range is 1..XMAX.
REQ-003 Parameter: YMAX, default 28, bottom legal row; legal y range is 1..YMAX.
REQ-004 Port: clk  input  1  system clock (25 MHz pixel clock domain).
REQ-005 Port: rst  input  1  reset; synchronous, active-high, sampled on rising clk.
REQ-006 Port: tick  input  1  one-cycle move strobe; one step per strobe.
REQ-007 Port: dir  input  2  requested heading: 0=up (y-1), 1=down (y+1), 2=left (x-1), 3=right (x+1).
REQ-008 Port: add  input  1  food-eaten level from the food block; stays high for one or more cycles per eat event.
REQ-009 Port: qx  input  6  render query column.
REQ-010 Port: qy  input  6  render query row.
REQ-011 Port: headx  output  6  current head column.
REQ-012 Port: heady  output  6  current head row.
REQ-013 Port: length  output  6  current segment count, head included.
REQ-014 Port: qhit  output  1  registered: (qx,qy) occupied by an active segment.
REQ-015 Port: dead  output  1  high once a wall or self collision is detected.

Function
REQ-016 Body storage: segment arrays sx[0..MAXLEN-1], sy[0..MAXLEN-1]; index 0 is the head; segments with index < length are active.
REQ-017 FSM states: RUN, MOVE, CHECK, DEAD.
REQ-018 RUN: on tick, compute next head from the effective heading, then go to MOVE; without tick, stay in RUN.
REQ-019 Heading: a dir that is the exact reverse of the current heading is ignored; otherwise dir is latched as the heading on the tick cycle.
REQ-020 Wall: a next head with x=0, x>XMAX, y=0, or y>YMAX sends the FSM directly to DEAD; segments stay unchanged.
REQ-021 MOVE (1 cycle): sx/sy[i] <= sx/sy[i-1] for i=1..MAXLEN-1, and segment 0 <= next head.
REQ-022 Growth in MOVE: if grow_pending=1 and length<MAXLEN, length increments by 1 and grow_pending clears; the new tail is the old last segment.
REQ-023 Growth at MAXLEN: if length=MAXLEN, grow_pending clears with no length change.
REQ-024 grow_pending: set on the rising edge of add (add=1, previous add=0); a held add level sets it only once.
REQ-025 Edge collision: an add rising edge in the same cycle as MOVE clearing grow_pending leaves grow_pending=1.
REQ-026 CHECK: iterate k=1..length-1 with one comparison per cycle; if segment k equals the head, go to DEAD.
REQ-027 CHECK exit: after the last k without a match, return to RUN; CHECK lasts length-1 cycles.
REQ-028 Busy ticks: tick arriving in MOVE or CHECK is dropped; it is not queued.
REQ-029 DEAD is absorbing: dead=1; segments, length, and headx/heady are frozen; tick and add are ignored until rst.
REQ-030 headx/heady equal segment 0 at all times and update in the cycle after MOVE.
REQ-031 qhit latency: qhit is valid one clk after qx/qy are applied; qhit=1 if any active segment matches; qhit is evaluated in every state, including DEAD.
REQ-032 Arithmetic: all coordinate arithmetic is 6-bit unsigned; the wall check is done before any wrap can occur.

Reset
REQ-033 On rst=1 at a clk edge: FSM=RUN, heading=right, length=3, segments 0..2=(20,15),(19,15),(18,15), remaining segments=(0,0), grow_pending=0, previous-add register=0, dead=0, qhit=0.
REQ-034 Priority: rst has priority over all inputs in any state, including mid-CHECK and DEAD.

Verification
REQ-035 Move: after reset, tick with dir=3 -> after MOVE, head=(21,15) and segment 2=(19,15); dead=0; length=3.
REQ-036 Grow: add held high for 100 cycles, then 2 ticks -> length=4 after the first MOVE and still 4 after the second (single grow per add edge).
REQ-037 Reversal: dir=2 while heading right, then tick -> head=(21,15); the heading is unchanged.
REQ-038 Wall: tick right 18 times from reset -> head=(38,15); the 19th tick -> dead=1, head stays (38,15), and further ticks have no effect.
REQ-039 Self collision: grow to length 5, then tick with dirs down, left, up -> dead=1 at the end of CHECK.
REQ-040 Query/reset: qx=19, qy=15 after reset -> qhit=1 the next cycle; qx=22 -> qhit=0; assert rst mid-CHECK -> all REQ-033 values hold on the next cycle.
